// File: rtl/pmem_arbiter_ctrl.sv
// rtl/pmem_arbiter_ctrl.sv - I/D cache to single memory port arbiter with D priority and I starvation guard
module pmem_arbiter_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_pmem_address,
  input  logic         i_pmem_read,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic [31:0]  d_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  input  logic [255:0] pmem_rdata_c,
  input  logic         pmem_resp_c,
  output logic [31:0]  pmem_address_c,
  output logic         pmem_read_c,
  output logic         pmem_write_c,
  output logic [255:0] pmem_wdata_c,
  output logic         arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t         state_q, state_d;
  logic [3:0]     starve_q, starve_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic           write_q, write_d;
  logic           owner_d_q, owner_d_d;   // 1: D-cache owns the transaction, 0: I-cache
  logic [255:0]   rdata_q, rdata_d;

  logic           d_req;
  logic           i_forced;

  assign d_req    = d_pmem_read | d_pmem_write;
  assign i_forced = i_pmem_read && (starve_q == STARVE_LIM);

  // Next-state, capture and output decode; outputs depend only on registered state
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    write_d        = write_q;
    owner_d_d      = owner_d_q;
    rdata_d        = rdata_q;
    i_pmem_rdata   = '0;
    i_pmem_resp    = 1'b0;
    d_pmem_rdata   = '0;
    d_pmem_resp    = 1'b0;
    pmem_address_c = '0;
    pmem_read_c    = 1'b0;
    pmem_write_c   = 1'b0;
    pmem_wdata_c   = '0;
    arb_busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d   = GRANT_D;
          addr_d    = d_pmem_address;
          wdata_d   = d_pmem_wdata;
          // a simultaneous read and write request resolves to a read
          write_d   = d_pmem_write & ~d_pmem_read;
          owner_d_d = 1'b1;
          if (i_pmem_read && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_pmem_read) begin
          state_d   = GRANT_I;
          addr_d    = i_pmem_address;
          wdata_d   = '0;
          write_d   = 1'b0;
          owner_d_d = 1'b0;
          starve_d  = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        pmem_address_c = addr_q;
        pmem_wdata_c   = wdata_q;
        pmem_read_c    = ~write_q;
        pmem_write_c   = write_q;
        if (pmem_resp_c) begin
          if (!write_q) begin
            rdata_d = pmem_rdata_c;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        if (owner_d_q) begin
          d_pmem_resp  = 1'b1;
          d_pmem_rdata = write_q ? '0 : rdata_q;
        end else begin
          i_pmem_resp  = 1'b1;
          i_pmem_rdata = rdata_q;
        end
        // always pass through IDLE so a requester dropping its line is not re-granted
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      owner_d_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      owner_d_q <= owner_d_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter_ctrl.sv
// tb/tb_pmem_arbiter_ctrl.sv - scoreboard bench for pmem_arbiter_ctrl
module tb_pmem_arbiter_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_read;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [31:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [255:0] pmem_rdata_c;
  logic         pmem_resp_c;
  logic [31:0]  pmem_address_c;
  logic         pmem_read_c;
  logic         pmem_write_c;
  logic [255:0] pmem_wdata_c;
  logic         arb_busy;

  always #5 clk = ~clk;

  pmem_arbiter_ctrl #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_rdata_c(pmem_rdata_c), .pmem_resp_c(pmem_resp_c),
    .pmem_address_c(pmem_address_c), .pmem_read_c(pmem_read_c),
    .pmem_write_c(pmem_write_c), .pmem_wdata_c(pmem_wdata_c),
    .arb_busy(arb_busy)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } gnt_t;

  typedef struct {
    logic         owner_d;
    logic [255:0] rdata;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  int mem_lat  = 1;
  bit mem_hold = 1'b0;
  bit stray    = 1'b0;

  function automatic logic [255:0] line_for(input logic [31:0] a);
    if (a == 32'h100) return {32{8'hA5}};
    return {8{a ^ 32'hDEADBEEF}};
  endfunction

  task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic exp_gnt(input logic [31:0] a, input logic wr, input logic [255:0] wd);
    gnt_t g;
    g.addr = a; g.wr = wr; g.wdata = wd;
    gnt_q.push_back(g);
  endtask

  task automatic exp_rsp(input logic owner_d, input logic [255:0] rd);
    rsp_t r;
    r.owner_d = owner_d; r.rdata = rd;
    rsp_q.push_back(r);
  endtask

  // memory model: checks each new request against the grant scoreboard and answers after mem_lat cycles
  initial begin
    int           cnt;
    logic [31:0]  cap_addr;
    logic         cap_wr;
    logic [255:0] cap_wdata;
    gnt_t         g;
    cnt = 0; cap_addr = '0; cap_wr = 1'b0; cap_wdata = '0;
    pmem_resp_c = 1'b0;
    pmem_rdata_c = '0;
    forever begin
      @(posedge clk);
      #2;
      pmem_resp_c  = 1'b0;
      pmem_rdata_c = '0;
      if (mon_en && (pmem_read_c || pmem_write_c)) begin
        chk_b("rw_onehot", pmem_read_c & pmem_write_c, 1'b0);
        if (cnt == 0) begin
          cap_addr  = pmem_address_c;
          cap_wr    = pmem_write_c;
          cap_wdata = pmem_wdata_c;
          if (gnt_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_grant: got addr %h expected no request", pmem_address_c);
          end else begin
            g = gnt_q.pop_front();
            chk_w("grant_addr", 256'(pmem_address_c), 256'(g.addr));
            chk_b("grant_write", pmem_write_c, g.wr);
            chk_w("grant_wdata", pmem_wdata_c, g.wdata);
          end
        end else begin
          chk_w("hold_addr", 256'(pmem_address_c), 256'(cap_addr));
          chk_b("hold_write", pmem_write_c, cap_wr);
          chk_w("hold_wdata", pmem_wdata_c, cap_wdata);
        end
        cnt++;
        if (!mem_hold && cnt >= mem_lat) begin
          pmem_resp_c  = 1'b1;
          pmem_rdata_c = cap_wr ? {32{8'h5C}} : line_for(cap_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
      if (stray) begin
        pmem_resp_c  = 1'b1;
        pmem_rdata_c = {32{8'hEE}};
        stray = 1'b0;
      end
    end
  end

  // response monitor: pops the response scoreboard on every resp pulse
  initial begin
    rsp_t r;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (i_pmem_resp || d_pmem_resp) begin
        chk_b("resp_onehot", i_pmem_resp & d_pmem_resp, 1'b0);
        chk_b("resp_pmem_rd", pmem_read_c, 1'b0);
        chk_b("resp_pmem_wr", pmem_write_c, 1'b0);
        if (rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got i=%b d=%b expected none", i_pmem_resp, d_pmem_resp);
        end else begin
          r = rsp_q.pop_front();
          chk_b("resp_owner", d_pmem_resp, r.owner_d);
          chk_w("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, r.rdata);
          chk_w("other_rdata", d_pmem_resp ? i_pmem_rdata : d_pmem_rdata, '0);
        end
      end else begin
        chk_w("quiet_i_rdata", i_pmem_rdata, '0);
        chk_w("quiet_d_rdata", d_pmem_rdata, '0);
      end
      if (!arb_busy) begin
        chk_b("idle_pmem_rd", pmem_read_c, 1'b0);
        chk_b("idle_pmem_wr", pmem_write_c, 1'b0);
        chk_w("idle_pmem_addr", 256'(pmem_address_c), '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resps(input bit need_i, input bit need_d, output int cycles);
    bit gi, gd;
    gi = !need_i; gd = !need_d; cycles = 0;
    while (!(gi && gd) && cycles < 300) begin
      tick();
      cycles++;
      if (i_pmem_resp) begin gi = 1'b1; i_pmem_read = 1'b0; end
      if (d_pmem_resp) begin gd = 1'b1; d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    end
    if (!(gi && gd)) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got i=%b d=%b expected both done", gi, gd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nrd, rdcnt;
    bit gi;
    rst = 1'b0;
    i_pmem_address = '0; i_pmem_read = 1'b0;
    d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    chk_b("rst_busy", arb_busy, 1'b0);
    chk_b("rst_pmem_rd", pmem_read_c, 1'b0);
    chk_b("rst_pmem_wr", pmem_write_c, 1'b0);
    chk_b("rst_i_resp", i_pmem_resp, 1'b0);
    chk_b("rst_d_resp", d_pmem_resp, 1'b0);
    rst = 1'b1;
    tick();

    // I read alone, memory answers after 5 request cycles
    mem_lat = 5;
    exp_gnt(32'h100, 1'b0, '0);
    exp_rsp(1'b0, {32{8'hA5}});
    i_pmem_address = 32'h100; i_pmem_read = 1'b1;
    gi = 1'b0; n = 0; rdcnt = 0;
    while (!gi && n < 100) begin
      tick(); n++;
      if (pmem_read_c) rdcnt++;
      if (i_pmem_resp) begin gi = 1'b1; i_pmem_read = 1'b0; end
    end
    chk_b("s1_done", gi, 1'b1);
    chk_w("s1_read_cycles", 256'(rdcnt), 256'(5));
    tick();

    // I and D raised together: D first, then I
    mem_lat = 1;
    exp_gnt(32'h180, 1'b0, '0);
    exp_rsp(1'b1, line_for(32'h180));
    exp_gnt(32'h140, 1'b0, '0);
    exp_rsp(1'b0, line_for(32'h140));
    i_pmem_address = 32'h140; i_pmem_read = 1'b1;
    d_pmem_address = 32'h180; d_pmem_read = 1'b1;
    wait_resps(1'b1, 1'b1, n);
    tick();

    // D continuously requesting with I waiting: 4 D grants, I, then D resumes
    for (int k = 0; k < 4; k++) begin
      exp_gnt(32'h300, 1'b0, '0);
      exp_rsp(1'b1, line_for(32'h300));
    end
    exp_gnt(32'h400, 1'b0, '0);
    exp_rsp(1'b0, line_for(32'h400));
    for (int k = 0; k < 2; k++) begin
      exp_gnt(32'h300, 1'b0, '0);
      exp_rsp(1'b1, line_for(32'h300));
    end
    d_pmem_address = 32'h300; d_pmem_read = 1'b1;
    i_pmem_address = 32'h400; i_pmem_read = 1'b1;
    gi = 1'b0; nrd = 0; n = 0;
    while (!(gi && nrd == 6) && n < 300) begin
      tick(); n++;
      if (i_pmem_resp) begin
        gi = 1'b1; i_pmem_read = 1'b0;
        chk_w("starve_d_before_i", 256'(nrd), 256'(4));
      end
      if (d_pmem_resp) begin
        nrd++;
        if (nrd == 6) d_pmem_read = 1'b0;
      end
    end
    chk_b("s3_done", gi && (nrd == 6), 1'b1);
    tick();

    // D write; wdata, address and request change after the grant
    mem_lat = 3;
    exp_gnt(32'h200, 1'b1, {8{32'h12345678}});
    exp_rsp(1'b1, '0);
    d_pmem_address = 32'h200; d_pmem_wdata = {8{32'h12345678}}; d_pmem_write = 1'b1;
    tick();
    d_pmem_wdata = {8{32'hFFFF0000}}; d_pmem_address = 32'h999; d_pmem_write = 1'b0;
    wait_resps(1'b0, 1'b1, n);
    d_pmem_wdata = '0;
    tick();

    // reset while in GRANT_D, then a stray memory response
    mem_hold = 1'b1;
    exp_gnt(32'h500, 1'b0, '0);
    d_pmem_address = 32'h500; d_pmem_read = 1'b1;
    repeat (3) tick();
    chk_b("s5_busy_before", arb_busy, 1'b1);
    rst = 1'b0;
    tick();
    chk_b("s5_busy_after", arb_busy, 1'b0);
    chk_b("s5_pmem_rd", pmem_read_c, 1'b0);
    chk_b("s5_pmem_wr", pmem_write_c, 1'b0);
    chk_w("s5_pmem_addr", 256'(pmem_address_c), '0);
    chk_b("s5_d_resp", d_pmem_resp, 1'b0);
    rst = 1'b1; d_pmem_read = 1'b0; mem_hold = 1'b0;
    tick();
    stray = 1'b1;
    repeat (3) tick();
    chk_b("s5_stray_ignored", arb_busy, 1'b0);

    // D read and write both high: read performed, minimum latency
    mem_lat = 1;
    exp_gnt(32'h600, 1'b0, '0);
    exp_rsp(1'b1, line_for(32'h600));
    d_pmem_address = 32'h600; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    wait_resps(1'b0, 1'b1, n);
    chk_w("s6_latency", 256'(n), 256'(2));

    repeat (4) tick();
    chk_w("gnt_queue_empty", 256'(gnt_q.size()), '0);
    chk_w("rsp_queue_empty", 256'(rsp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
